button_event_queue: RTL and testbench

Converts the level-style virtual button interface produced by the UART MinOS (`button_pressed` / `button_index`) into discrete press/release events. It buffers those events in a small show-ahead FIFO and hands them to the display/game logic over a valid/ready handshake. It sits directly downstream of `min_os` and upstream of the flashes/blocks display stage, so that short presses are not lost while the consumer is busy. Overflow is counted and flagged rather than silently ignored.

---
 rtl/button_event_queue_if.sv | 43 ++++
 rtl/button_event_queue.sv | 97 +++++++++
 tb/tb_button_event_queue.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_queue_if.sv
// Event-queue bus: level button input from MinOS, event handshake out.
// master = MinOS/consumer side, slave = button_event_queue.
//   button_pressed/button_index : held-button level and index
//   ev_valid/ev_kind/ev_index/ev_ready : show-ahead event handshake
//   count/overflow/drop_count : occupancy and overflow status
interface button_event_queue_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 8
);
    logic                     button_pressed;
    logic [IDX_W-1:0]         button_index;
    logic                     ev_valid;
    logic                     ev_kind;
    logic [IDX_W-1:0]         ev_index;
    logic                     ev_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [7:0]               drop_count;

    modport master (
        output button_pressed,
        output button_index,
        output ev_ready,
        input  ev_valid,
        input  ev_kind,
        input  ev_index,
        input  count,
        input  overflow,
        input  drop_count
    );

    modport slave (
        input  button_pressed,
        input  button_index,
        input  ev_ready,
        output ev_valid,
        output ev_kind,
        output ev_index,
        output count,
        output overflow,
        output drop_count
    );
endinterface

// File: rtl/button_event_queue.sv
// Turns the MinOS held-button level into press/release events and
// buffers them in a show-ahead FIFO with sticky overflow and drop count.
// Ports: CLK, RST (sync, active high), bus (button_event_queue_if.slave).
module button_event_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    button_event_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic             r_pressed_q;
    logic [IDX_W-1:0] r_held_idx;
    logic [IDX_W:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [7:0]       r_drop_count;

    logic             w_press;
    logic             w_release;
    logic             w_event;
    logic [IDX_W:0]   w_payload;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [IDX_W:0]   w_head;

    // An index change while still held is not an event.
    assign w_press   = bus.button_pressed & ~r_pressed_q;
    assign w_release = ~bus.button_pressed & r_pressed_q;
    assign w_event   = w_press | w_release;
    assign w_payload = w_press ? {1'b1, bus.button_index}
                               : {1'b0, r_held_idx};

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL);
    assign w_pop   = w_valid & bus.ev_ready;
    // A pop frees the head slot this same edge, so full+pop still accepts.
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    assign w_head = r_mem[r_rd_ptr];

    assign bus.ev_valid   = w_valid;
    assign bus.ev_kind    = w_valid & w_head[IDX_W];
    assign bus.ev_index   = w_valid ? w_head[IDX_W-1:0] : '0;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;

    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_mem[r_wr_ptr] <= w_payload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pressed_q  <= 1'b0;
            r_held_idx   <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_pressed_q <= bus.button_pressed;
            if (w_press) begin
                r_held_idx <= bus.button_index;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_button_event_queue.sv
// Randomised self-checking bench for button_event_queue against a
// queue-based event model.
module tb_button_event_queue;
    localparam int DEPTH = 8;
    localparam int IDX_W = 8;

    logic CLK;
    logic RST;

    button_event_queue_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    button_event_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] m_q[$];
    logic       m_prev;
    logic [7:0] m_held;
    logic       m_ovf;
    int         m_drops;

    function automatic logic [22:0] dut_vec();
        return {bus.ev_valid, bus.ev_kind, bus.ev_index, bus.count,
                bus.overflow, bus.drop_count};
    endfunction

    function automatic logic [22:0] exp_vec();
        logic [8:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 9'd0;
        return {(m_q.size() > 0), h, 4'(m_q.size()), m_ovf, 8'(m_drops)};
    endfunction

    // Drives one clock of stimulus and advances the model; ends at negedge.
    task automatic cycle(input logic rst, input logic bp,
                         input logic [7:0] idx, input logic rdy);
        logic       ev;
        logic [8:0] pl;
        RST = rst;
        bus.button_pressed = bp;
        bus.button_index = idx;
        bus.ev_ready = rdy;
        if (rst) begin
            m_q.delete();
            m_prev = 1'b0;
            m_held = '0;
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            ev = 1'b0;
            pl = '0;
            if (bp && !m_prev) begin
                ev = 1'b1;
                pl = {1'b1, idx};
                m_held = idx;
            end else if (!bp && m_prev) begin
                ev = 1'b1;
                pl = {1'b0, m_held};
            end
            m_prev = bp;
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(pl);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 8'h33, 1);
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_single_tap();
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 1, 5, 0);
        cycle(0, 0, 5, 0);
        n_checks++;
        if ({bus.count, bus.ev_kind, bus.ev_index} !== {4'd2, 9'h105}) begin
            n_fail++;
            $display("FAIL tap_head1: got cnt=%0d %b/%0d expected 2 1/5",
                     bus.count, bus.ev_kind, bus.ev_index);
        end
        cycle(0, 0, 0, 1);
        n_checks++;
        if ({bus.ev_valid, bus.ev_kind, bus.ev_index} !== {1'b1, 9'h005}) begin
            n_fail++;
            $display("FAIL tap_head2: got v=%b %b/%0d expected 1 0/5",
                     bus.ev_valid, bus.ev_kind, bus.ev_index);
        end
        cycle(0, 0, 0, 1);
        n_checks++;
        if (dut_vec() !== exp_vec() || bus.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tap_empty: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_index_change();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 3, 0);
        cycle(0, 1, 7, 0);
        cycle(0, 1, 7, 0);
        cycle(0, 0, 7, 0);
        n_checks++;
        if (bus.count !== 4'd2) begin
            n_fail++;
            $display("FAIL idxchg_count: got %0d expected 2", bus.count);
        end
        n_checks++;
        if ({bus.ev_kind, bus.ev_index} !== 9'h103) begin
            n_fail++;
            $display("FAIL idxchg_first: got %h expected 103",
                     {bus.ev_kind, bus.ev_index});
        end
        cycle(0, 0, 0, 1);
        n_checks++;
        if ({bus.ev_kind, bus.ev_index} !== 9'h003) begin
            n_fail++;
            $display("FAIL idxchg_second: got %h expected 003",
                     {bus.ev_kind, bus.ev_index});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ix [5];
        logic [8:0] e;
        cycle(1, 0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            ix[t] = 8'($urandom_range(0, 255));
            cycle(0, 1, ix[t], 0);
            cycle(0, 0, 0, 0);
        end
        n_checks++;
        if ({bus.count, bus.overflow, bus.drop_count} !== {4'd8, 1'b1, 8'd2}) begin
            n_fail++;
            $display("FAIL ovf_status: got cnt=%0d ovf=%b drops=%0d expected 8 1 2",
                     bus.count, bus.overflow, bus.drop_count);
        end
        for (int k = 0; k < 8; k++) begin
            e = {(k % 2 == 0), ix[k/2]};
            n_checks++;
            if ({bus.ev_valid, bus.ev_kind, bus.ev_index} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL ovf_order[%0d]: got %h expected %h", k,
                         {bus.ev_valid, bus.ev_kind, bus.ev_index}, {1'b1, e});
            end
            cycle(0, 0, 0, 1);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL ovf_drained: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full_pop_push();
        cycle(1, 0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            cycle(0, 1, 8'(t + 20), 0);
            cycle(0, 0, 0, 0);
        end
        cycle(0, 1, 9, 1);
        n_checks++;
        if ({bus.count, bus.drop_count, bus.overflow} !== {4'd8, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL fullpp_status: got cnt=%0d drops=%0d ovf=%b expected 8 0 0",
                     bus.count, bus.drop_count, bus.overflow);
        end
        for (int k = 0; k < 7; k++) cycle(0, 1, 9, 1);
        n_checks++;
        if ({bus.count, bus.ev_kind, bus.ev_index} !== {4'd1, 9'h109}) begin
            n_fail++;
            $display("FAIL fullpp_tail: got cnt=%0d %h expected 1 109",
                     bus.count, {bus.ev_kind, bus.ev_index});
        end
        cycle(0, 0, 0, 1);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fullpp_model: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap_saturation();
        logic [8:0] sent[$];
        logic [8:0] got[$];
        logic [7:0] ix;
        int         bad;
        cycle(1, 0, 0, 0);
        for (int t = 0; t < 151; t++) begin
            ix = 8'($urandom_range(0, 255));
            for (int ph = 0; ph < 2; ph++) begin
                if (bus.ev_valid) got.push_back({bus.ev_kind, bus.ev_index});
                if (t < 150) begin
                    if (ph == 0) sent.push_back({1'b1, ix});
                    else sent.push_back({1'b0, ix});
                    cycle(0, (ph == 0), ix, 1);
                end else begin
                    cycle(0, 0, 0, 1);
                end
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL wrap_step[%0d]: got %h expected %h",
                             2 * t + ph, dut_vec(), exp_vec());
                end
            end
        end
        bad = (got.size() != sent.size()) ? 1 : 0;
        for (int k = 0; k < got.size() && k < sent.size(); k++)
            if (got[k] !== sent[k]) bad++;
        n_checks++;
        if (bad != 0 || bus.overflow !== 1'b0 || sent.size() != 300) begin
            n_fail++;
            $display("FAIL wrap_order: got %0d events (%0d bad) ovf=%b expected 300 0 0",
                     got.size(), bad, bus.overflow);
        end
        for (int t = 0; t < 150; t++) begin
            ix = 8'($urandom_range(0, 255));
            cycle(0, 1, ix, 0);
            cycle(0, 0, ix, 0);
        end
        n_checks++;
        if ({bus.drop_count, bus.overflow, bus.count} !== {8'd255, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL saturate: got drops=%0d ovf=%b cnt=%0d expected 255 1 8",
                     bus.drop_count, bus.overflow, bus.count);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL saturate_model: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic bp;
        logic rdy;
        logic [7:0] ix;
        cycle(1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            bp  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            ix  = 8'($urandom_range(0, 3));
            cycle((k % 197) == 196, bp, ix, rdy);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h",
                         k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 2, 0);
        cycle(0, 0, 2, 0);
        cycle(0, 1, 6, 1);
        n_checks++;
        if (bus.count !== 4'd4) begin
            n_fail++;
            $display("FAIL rstmid_pre: got cnt=%0d expected 4", bus.count);
        end
        cycle(1, 1, 6, 1);
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_fail++;
            $display("FAIL rstmid_during: got %h expected 0", dut_vec());
        end
        cycle(1, 1, 6, 0);
        cycle(0, 1, 6, 0);
        n_checks++;
        if ({bus.ev_valid, bus.count, bus.ev_kind, bus.ev_index}
                !== {1'b1, 4'd1, 9'h106}) begin
            n_fail++;
            $display("FAIL rstmid_after: got v=%b cnt=%0d %h expected 1 1 106",
                     bus.ev_valid, bus.count, {bus.ev_kind, bus.ev_index});
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.button_pressed = 1'b0;
        bus.button_index = '0;
        bus.ev_ready = 1'b0;
        m_prev = 1'b0;
        m_held = '0;
        m_ovf = 1'b0;
        m_drops = 0;
        @(negedge CLK);
        test_reset();
        test_single_tap();
        test_index_change();
        test_overflow();
        test_full_pop_push();
        test_wrap_saturation();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
